// File: rtl/dpc_bp_list_ctrl_pkg.sv
// Shared types and constants for the DPC bad-pixel list controller.
// Coordinate width, list sizing, FSM encoding and the list-RAM read latency.
package dpc_pkg;

  localparam int DPC_CNT_WIDTH     = 10;
  localparam int DPC_AUTO_BP_NUM   = 256;
  localparam int DPC_AUTO_BP_BIT   = 8;
  localparam int BPLIST_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } bplist_state_t;

  typedef struct packed {
    logic [DPC_CNT_WIDTH-1:0] y;
    logic [DPC_CNT_WIDTH-1:0] x;
  } bp_coord_t;

endpackage

// File: rtl/dpc_bp_list_ctrl_if.sv
// AXI-Stream-style list output bundle: the controller is the master,
// the host/DMA side is the slave.
interface dpc_bp_list_ctrl_if #(
  parameter int CNT_WIDTH = 10
);
  logic                   m_tvalid;
  logic                   m_tready;
  logic [2*CNT_WIDTH-1:0] m_tdata;
  logic                   m_tlast;

  modport master (output m_tvalid, output m_tdata, output m_tlast, input m_tready);
  modport slave  (input m_tvalid, input m_tdata, input m_tlast, output m_tready);
endinterface

// File: rtl/dpc_bp_list_ctrl_ram.sv
// Simple dual-port list storage: one write port, one read port with a
// registered, enable-held output. Storage is not reset.
module dpc_bp_list_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Read data holds while i_rd_en is low so a stalled entry stays put.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dpc_bp_list_ctrl.sv
// One-pass bad-pixel capture controller: arms, gates the detector for one frame,
// stores up to AUTO_BP_NUM {y,x} reports, then streams them out. Optional irq: DPC_BPLIST_IRQ_EN.
module dpc_bp_list_ctrl
  import dpc_pkg::*;
#(
  parameter int CNT_WIDTH   = DPC_CNT_WIDTH,
  parameter int AUTO_BP_NUM = DPC_AUTO_BP_NUM,
  parameter int AUTO_BP_BIT = DPC_AUTO_BP_BIT
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   abort,
  output logic                   det_enable,
  input  logic                   det_sof,
  input  logic                   det_bp_valid,
  input  logic [CNT_WIDTH-1:0]   det_bp_x,
  input  logic [CNT_WIDTH-1:0]   det_bp_y,
  input  logic                   det_frame_done,
  dpc_bp_list_ctrl_if.master     m_axis,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [AUTO_BP_BIT:0]   bp_count
`ifdef DPC_BPLIST_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam logic [AUTO_BP_BIT:0] L_NUM = AUTO_BP_NUM[AUTO_BP_BIT:0];

  function automatic logic [AUTO_BP_BIT:0] sat_inc(input logic [AUTO_BP_BIT:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  bplist_state_t              r_state;
  bplist_state_t              w_state_nxt;
  logic [AUTO_BP_BIT:0]       r_wr_ptr;
  logic [AUTO_BP_BIT:0]       r_rd_ptr;
  logic [AUTO_BP_BIT:0]       r_bp_count;
  logic                       r_overflow;
  logic                       r_det_enable;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_vld_p1;
  logic                       r_last_p1;
  logic                       r_tvalid;
  logic                       r_tlast;
  logic [2*CNT_WIDTH-1:0]     r_tdata;
  logic [2*CNT_WIDTH-1:0]     w_rd_data;
  bp_coord_t                  w_wr_coord;
  logic                       w_arm;
  logic                       w_cap_hit;
  logic                       w_full;
  logic                       w_wr_en;
  logic                       w_out_free;
  logic                       w_p1_free;
  logic                       w_rd_en;
  logic                       w_last_beat;
  logic                       w_drain_end;
  logic                       w_drain_entry;

  assign w_wr_coord.y  = det_bp_y;
  assign w_wr_coord.x  = det_bp_x;
  assign w_arm         = !abort && start && (r_state == IDLE || r_state == DONE);
  assign w_cap_hit     = (r_state == CAPTURE) && det_bp_valid;
  assign w_full        = (r_wr_ptr >= L_NUM);
  assign w_wr_en       = w_cap_hit && !w_full;

  // Two-stage elastic read path: p1 is the RAM output, the output register follows.
  assign w_out_free    = !r_tvalid || m_axis.m_tready;
  assign w_p1_free     = !r_vld_p1 || w_out_free;
  assign w_rd_en       = (r_state == DRAIN) && (r_rd_ptr < r_wr_ptr) && w_p1_free;
  assign w_last_beat   = r_tvalid && m_axis.m_tready && r_tlast;
  assign w_drain_end   = (r_state == DRAIN) && ((r_wr_ptr == '0) || w_last_beat);
  assign w_drain_entry = (r_state == CAPTURE) && (w_state_nxt == DRAIN);

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start)          w_state_nxt = ARMED;
        ARMED:   if (det_sof)        w_state_nxt = CAPTURE;
        CAPTURE: if (det_frame_done) w_state_nxt = DRAIN;
        DRAIN:   if (w_drain_end)    w_state_nxt = DONE;
        DONE:    if (start)          w_state_nxt = ARMED;
        default:                     w_state_nxt = IDLE;
      endcase
    end
  end

  dpc_bp_list_ram #(
    .DEPTH (AUTO_BP_NUM),
    .AW    (AUTO_BP_BIT),
    .DW    (2*CNT_WIDTH)
  ) u_ram (
    .clk       (aclk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AUTO_BP_BIT-1:0]),
    .i_wr_data (w_wr_coord),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[AUTO_BP_BIT-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= IDLE;
      r_det_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_bp_count   <= '0;
      r_overflow   <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_last_p1    <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_det_enable <= (w_state_nxt == ARMED) || (w_state_nxt == CAPTURE);
      r_busy       <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
      r_done       <= (w_state_nxt == DONE);

      if (w_arm) begin
        r_wr_ptr   <= '0;
        r_bp_count <= '0;
        r_overflow <= 1'b0;
      end else if (w_cap_hit) begin
        r_bp_count <= sat_inc(r_bp_count);
        if (w_full) r_overflow <= 1'b1;
        else        r_wr_ptr   <= r_wr_ptr + 1'b1;
      end

      // p0: address issue / p1: RAM output / p2: output register
      if (abort || w_drain_entry) begin
        r_rd_ptr  <= '0;
        r_vld_p1  <= 1'b0;
        r_last_p1 <= 1'b0;
        r_tvalid  <= 1'b0;
        r_tlast   <= 1'b0;
      end else begin
        if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_p1_free) begin
          r_vld_p1  <= w_rd_en;
          r_last_p1 <= (r_rd_ptr == (r_wr_ptr - 1'b1));
        end
        if (w_out_free) begin
          r_tvalid <= r_vld_p1;
          r_tlast  <= r_vld_p1 && r_last_p1;
          if (r_vld_p1) r_tdata <= w_rd_data;
        end
      end
    end
  end

`ifdef DPC_BPLIST_IRQ_EN
  logic r_irq;

  // Completion and first drop of a pass share one pulse if coincident.
  always_ff @(posedge aclk) begin
    if (areset) r_irq <= 1'b0;
    else        r_irq <= (!abort && w_drain_end) || (w_cap_hit && w_full && !r_overflow);
  end

  assign irq = r_irq;
`endif

  assign det_enable      = r_det_enable;
  assign busy            = r_busy;
  assign done            = r_done;
  assign overflow        = r_overflow;
  assign bp_count        = r_bp_count;
  assign m_axis.m_tvalid = r_tvalid;
  assign m_axis.m_tlast  = r_tlast;
  assign m_axis.m_tdata  = r_tdata;

endmodule

// File: tb/tb_dpc_bp_list_ctrl.sv
// Directed bench for dpc_bp_list_ctrl: capture passes, overflow, empty pass,
// back-pressure, abort and mid-drain reset, against hand-derived expectations.
module tb_dpc_bp_list_ctrl;
  import dpc_pkg::*;

  logic        aclk = 1'b0;
  logic        areset, start, abort, det_enable, det_sof, det_bp_valid, det_frame_done;
  logic [9:0]  det_bp_x, det_bp_y;
  logic        busy, done, overflow;
  logic [8:0]  bp_count;
  logic        irq;
  logic [19:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  dpc_bp_list_ctrl_if #(.CNT_WIDTH(10)) u_if ();

  dpc_bp_list_ctrl u_dut (
    .aclk           (aclk),
    .areset         (areset),
    .start          (start),
    .abort          (abort),
    .det_enable     (det_enable),
    .det_sof        (det_sof),
    .det_bp_valid   (det_bp_valid),
    .det_bp_x       (det_bp_x),
    .det_bp_y       (det_bp_y),
    .det_frame_done (det_frame_done),
    .m_axis         (u_if),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .bp_count       (bp_count)
`ifdef DPC_BPLIST_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

`ifndef DPC_BPLIST_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.delete();
  endtask

  task automatic sof();
    det_sof = 1'b1;
    step();
    det_sof = 1'b0;
  endtask

  task automatic report(input logic [9:0] x, input logic [9:0] y);
    det_bp_valid = 1'b1;
    det_bp_x     = x;
    det_bp_y     = y;
    if (exp_q.size() < 256) exp_q.push_back({y, x});
    step();
    det_bp_valid = 1'b0;
  endtask

  task automatic frame_done();
    det_frame_done = 1'b1;
    step();
    det_frame_done = 1'b0;
  endtask

  // Called in the first DRAIN cycle. mode 0: ready high; mode 1: ready toggles 1/0.
  task automatic drain(input int n_exp, input int mode, input int bound, input string tag);
    int          beats = 0;
    int          first = -1;
    int          cyc   = 0;
    logic        stall = 1'b0;
    logic [19:0] hold  = '0;
    while (cyc < bound && !done) begin
      u_if.m_tready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (stall) begin
        chk({tag, "_hold_vld"}, u_if.m_tvalid, 1);
        chk({tag, "_hold_data"}, u_if.m_tdata, hold);
      end
      if (u_if.m_tvalid && u_if.m_tready) begin
        if (first < 0) first = cyc;
        if (beats < n_exp) chk({tag, "_data"}, u_if.m_tdata, exp_q[beats]);
        chk({tag, "_last"}, u_if.m_tlast, (beats == n_exp - 1));
        beats++;
      end
      stall = u_if.m_tvalid && !u_if.m_tready;
      hold  = u_if.m_tdata;
      step();
      cyc++;
    end
    u_if.m_tready = 1'b0;
    chk({tag, "_beats"}, beats, n_exp);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_vld_after"}, u_if.m_tvalid, 0);
    if (n_exp > 0) chk({tag, "_first_lat"}, first, BPLIST_RD_LATENCY + 1);
    else           chk({tag, "_done_lat"}, (cyc <= 2), 1);
`ifdef DPC_BPLIST_IRQ_EN
    chk({tag, "_irq_done"}, irq, 1);
`endif
  endtask

  initial begin
    int irq_n;
    int irq_at;
    areset = 1'b1; start = 1'b0; abort = 1'b0; det_sof = 1'b0;
    det_bp_valid = 1'b0; det_frame_done = 1'b0; det_bp_x = '0; det_bp_y = '0;
    u_if.m_tready = 1'b0;
    step(); step();
    areset = 1'b0;
    chk("rst_det_en", det_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", bp_count, 0);
    chk("rst_tvalid", u_if.m_tvalid, 0);
    chk("rst_tdata", u_if.m_tdata, 0);
    chk("rst_tlast", u_if.m_tlast, 0);

    // Three reports, free-running sink
    arm();
    chk("t1_armed_en", det_enable, 1);
    chk("t1_armed_busy", busy, 1);
    report(10'd100, 10'd100);   // ignored while ARMED
    chk("t1_armed_ignore", bp_count, 0);
    exp_q.delete();
    sof();
    report(10'd5, 10'd7);
    report(10'd9, 10'd1);
    report(10'd639, 10'd511);
    frame_done();
    chk("t1_drain_en", det_enable, 0);
    chk("t1_drain_vld0", u_if.m_tvalid, 0);
    drain(3, 0, 20, "t1");
    chk("t1_cnt", bp_count, 3);
    chk("t1_ovf", overflow, 0);
    chk("t1_busy", busy, 0);
    chk("t1_d0", exp_q[0], 20'h01C05);

    // 300 reports into a 256-entry list
    arm();
    chk("t2_arm_cnt", bp_count, 0);
    sof();
    irq_n = 0; irq_at = 0;
    for (int i = 0; i < 300; i++) begin
      report(i[9:0], 10'((i * 3) & 1023));
      if (irq) begin irq_n++; irq_at = i + 1; end
    end
    chk("t2_ovf", overflow, 1);
    chk("t2_cnt", bp_count, 300);
`ifdef DPC_BPLIST_IRQ_EN
    chk("t2_irq_n", irq_n, 1);
    chk("t2_irq_at", irq_at, 257);
`endif
    frame_done();
    drain(256, 0, 600, "t2");
    chk("t2_cnt_after", bp_count, 300);

    // Empty pass
    arm();
    chk("t3_ovf_clr", overflow, 0);
    sof();
    frame_done();
    drain(0, 0, 5, "t3");
    chk("t3_cnt", bp_count, 0);

    // Alternating back-pressure
    arm();
    sof();
    for (int i = 0; i < 4; i++) report(10'(10 + i), 10'(20 + i));
    frame_done();
    drain(4, 1, 40, "t4");
    chk("t4_cnt", bp_count, 4);

    // Abort mid-capture, then restart
    arm();
    sof();
    report(10'd1, 10'd2);
    report(10'd3, 10'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_det_en", det_enable, 0);
    chk("t5_tvalid", u_if.m_tvalid, 0);
    chk("t5_cnt_kept", bp_count, 2);
    arm();
    chk("t5_cnt_clr", bp_count, 0);
    sof();
    det_sof = 1'b1;             // sof during capture is ignored
    report(10'd3, 10'd4);
    det_sof = 1'b0;
    chk("t5_cnt_new", bp_count, 1);
    frame_done();
    drain(1, 0, 10, "t5");

    // Reset during drain with start asserted
    arm();
    sof();
    for (int i = 0; i < 4; i++) report(10'(i), 10'(i + 1));
    frame_done();
    step(); step();
    chk("t6_pre_vld", u_if.m_tvalid, 1);
    areset = 1'b1; start = 1'b1;
    step();
    chk("t6_tvalid", u_if.m_tvalid, 0);
    chk("t6_tdata", u_if.m_tdata, 0);
    chk("t6_tlast", u_if.m_tlast, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_det_en", det_enable, 0);
    chk("t6_cnt", bp_count, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_irq", irq, 0);
    areset = 1'b0; start = 1'b0;
    step();
    chk("t6_start_ignored", busy, 0);
    chk("t6_det_en_after", det_enable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
